lc3b_dm_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache between the LC-3b multicycle CPU memory port and a 128-bit line-based physical memory.
- The CPU side uses the same word interface the core drives: read/write strobes, 16-bit address and data, 2-bit byte mask, and a single mem_resp.
- The pmem side moves whole 16-byte lines, using a per-byte write mask for write-through stores.

---
 rtl/lc3b_dm_cache_pkg.sv | 30 +++
 rtl/lc3b_dm_cache_array.sv | 61 ++++++
 rtl/lc3b_dm_cache.sv | 187 ++++++++++++++++++
 tb/tb_lc3b_dm_cache.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_dm_cache_pkg.sv
// Shared LC-3b cache types.
//   lc3b_word / lc3b_mem_wmask : CPU-side word and byte-mask types
//   lc3b_c_line / lc3b_c_mask  : 128-bit pmem line and its 16-bit byte mask
//   lc3b_c_offset              : byte offset within a line
//   lc3b_cache_state           : cache controller states
//   word_byte_mask()           : places a 2-bit word byte mask into a line byte mask
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [127:0] lc3b_c_line;
    typedef logic [15:0]  lc3b_c_mask;
    typedef logic [3:0]   lc3b_c_offset;

    typedef enum logic [1:0] {
        C_IDLE  = 2'b00,
        C_FILL  = 2'b01,
        C_WRITE = 2'b10
    } lc3b_cache_state;

    // Word w of a line owns bytes {2w+1, 2w}.
    function automatic lc3b_c_mask word_byte_mask(input logic [2:0] word_sel,
                                                  input lc3b_mem_wmask be);
        lc3b_c_mask m;
        m = 16'h0000;
        m[{word_sel, 1'b0} +: 2] = be;
        return m;
    endfunction

endpackage

// File: rtl/lc3b_dm_cache_array.sv
// Valid/tag/line storage for the direct-mapped cache.
//   clk, rst_n      : clock, async active-low reset (clears valid bits only)
//   index_i         : set selected for both reads and writes
//   rd_valid_o/rd_tag_o/rd_line_o : combinational read of the selected set
//   line_we_i, line_tag_i, line_data_i : full-line fill, sets valid
//   word_we_i, word_sel_i, word_data_i, word_be_i : byte-masked word update
module lc3b_cache_array
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = 3,
    parameter int TAG_W    = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [127:0]       rd_line_o,
    input  logic               line_we_i,
    input  logic [TAG_W-1:0]   line_tag_i,
    input  logic [127:0]       line_data_i,
    input  logic               word_we_i,
    input  logic [2:0]         word_sel_i,
    input  logic [15:0]        word_data_i,
    input  logic [1:0]         word_be_i
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    lc3b_c_line          line_q [NUM_SETS];

    assign rd_valid_o = valid_q[index_i];
    assign rd_tag_o   = tag_q[index_i];
    assign rd_line_o  = line_q[index_i];

    // Valid bits: cleared asynchronously, set by a line fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {NUM_SETS{1'b0}};
        end else if (line_we_i) begin
            valid_q[index_i] <= 1'b1;
        end
    end

    // Tag and line storage: not reset, a cleared valid bit masks stale contents.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[index_i]  <= line_tag_i;
            line_q[index_i] <= line_data_i;
        end else if (word_we_i) begin
            if (word_be_i[0]) begin
                line_q[index_i][{word_sel_i, 4'h0} +: 8] <= word_data_i[7:0];
            end
            if (word_be_i[1]) begin
                line_q[index_i][{word_sel_i, 4'h8} +: 8] <= word_data_i[15:8];
            end
        end
    end

endmodule

// File: rtl/lc3b_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between the LC-3b
// CPU word port and a 128-bit line memory.
//   CPU side : mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
//              mem_rdata, mem_resp (read hits answer in the request cycle)
//   pmem side: pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
//              pmem_rdata, pmem_resp
//   stats    : stat_hits, stat_misses, live only when LC3B_CACHE_STATS_EN is
//              defined, otherwise tied to zero.
module lc3b_dm_cache
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic [15:0]  pmem_wmask,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  stat_hits,
    output logic [15:0]  stat_misses
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 12 - INDEX_W;

    lc3b_cache_state      state_q;
    logic [INDEX_W-1:0]   index_s;
    logic [TAG_W-1:0]     tag_s;
    logic [2:0]           word_sel_s;
    logic [15:0]          line_addr_s;
    logic                 rd_valid_s;
    logic [TAG_W-1:0]     rd_tag_s;
    lc3b_c_line           rd_line_s;
    logic                 hit_s;
    logic                 read_hit_s;
    logic                 line_we_s;
    logic                 word_we_s;
    logic                 unused_addr_s;

    assign index_s       = mem_address[4 +: INDEX_W];
    assign tag_s         = mem_address[15 -: TAG_W];
    assign word_sel_s    = mem_address[3:1];
    assign line_addr_s   = {mem_address[15:4], 4'h0};
    assign unused_addr_s = mem_address[0];

    assign hit_s      = rd_valid_s && (rd_tag_s == tag_s);
    // A write takes priority over a simultaneous read.
    assign read_hit_s = (state_q == C_IDLE) && mem_read && !mem_write && hit_s;
    assign line_we_s  = (state_q == C_FILL) && pmem_resp;
    // Write-through updates the cached copy only if the line is present.
    assign word_we_s  = (state_q == C_WRITE) && pmem_resp && hit_s;

    lc3b_cache_array #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .index_i     (index_s),
        .rd_valid_o  (rd_valid_s),
        .rd_tag_o    (rd_tag_s),
        .rd_line_o   (rd_line_s),
        .line_we_i   (line_we_s),
        .line_tag_i  (tag_s),
        .line_data_i (pmem_rdata),
        .word_we_i   (word_we_s),
        .word_sel_i  (word_sel_s),
        .word_data_i (mem_wdata),
        .word_be_i   (mem_byte_enable)
    );

    // Controller state; pmem_resp outside FILL/WRITE is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (mem_write) begin
                        state_q <= C_WRITE;
                    end else if (mem_read && !hit_s) begin
                        state_q <= C_FILL;
                    end else begin
                        state_q <= C_IDLE;
                    end
                end
                C_FILL: begin
                    if (pmem_resp) begin
                        state_q <= C_IDLE;
                    end else begin
                        state_q <= C_FILL;
                    end
                end
                C_WRITE: begin
                    if (pmem_resp) begin
                        state_q <= C_IDLE;
                    end else begin
                        state_q <= C_WRITE;
                    end
                end
                default: begin
                    state_q <= C_IDLE;
                end
            endcase
        end
    end

    // Output decode: everything is zero unless the current state qualifies it.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        pmem_wmask   = 16'h0000;
        case (state_q)
            C_IDLE: begin
                if (read_hit_s) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rd_line_s[{word_sel_s, 4'h0} +: 16];
                end else begin
                    mem_resp  = 1'b0;
                end
            end
            C_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr_s;
            end
            C_WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = line_addr_s;
                pmem_wdata   = {8{mem_wdata}};
                pmem_wmask   = word_byte_mask(word_sel_s, mem_byte_enable);
                mem_resp     = pmem_resp;
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

`ifdef LC3B_CACHE_STATS_EN
    logic [15:0] hits_q;
    logic [15:0] misses_q;
    logic        just_filled_q;
    logic        fill_entry_s;

    assign fill_entry_s = (state_q == C_IDLE) && !mem_write && mem_read && !hit_s;

    // The response right after a fill completes a miss, so it is not a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q        <= 16'h0000;
            misses_q      <= 16'h0000;
            just_filled_q <= 1'b0;
        end else begin
            just_filled_q <= line_we_s;
            if (read_hit_s && !just_filled_q && (hits_q != 16'hFFFF)) begin
                hits_q <= hits_q + 16'h0001;
            end
            if (fill_entry_s && (misses_q != 16'hFFFF)) begin
                misses_q <= misses_q + 16'h0001;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = 16'h0000;
    assign stat_misses = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_dm_cache.sv
module tb_lc3b_dm_cache;

    localparam int LAT = 2;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [15:0]  pmem_wmask;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  stat_hits;
    logic [15:0]  stat_misses;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [15:0]  exp_q[$];
    logic [127:0] pmem_mem [int];

    lc3b_dm_cache #(.NUM_SETS(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_wmask      (pmem_wmask),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model_line(input logic [15:0] la);
        logic [127:0] l;
        if (pmem_mem.exists(int'(la))) begin
            l = pmem_mem[int'(la)];
        end else begin
            for (int w = 0; w < 8; w++) begin
                l[16*w +: 16] = 16'hA000 ^ (la | 16'(2 * w));
            end
        end
        return l;
    endfunction

    function automatic logic [15:0] model_word(input logic [15:0] a);
        logic [127:0] l;
        l = model_line({a[15:4], 4'h0});
        return l[16*a[3:1] +: 16];
    endfunction

    function automatic int stat_exp(input int v);
`ifdef LC3B_CACHE_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_stats(input string name);
        n_checks++;
        if (stat_hits !== 16'(stat_exp(exp_hits))) begin
            n_fail++;
            $display("FAIL %s stat_hits: got %0d expected %0d", name, stat_hits, stat_exp(exp_hits));
        end
        n_checks++;
        if (stat_misses !== 16'(stat_exp(exp_misses))) begin
            n_fail++;
            $display("FAIL %s stat_misses: got %0d expected %0d", name, stat_misses, stat_exp(exp_misses));
        end
    endtask

    // One CPU access with an in-line pmem responder of latency LAT.
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input int exp_reads, input int exp_writes, input int exp_cycles,
                          input string name);
        int cyc;
        int nrd;
        int nwr;
        int wait_cnt;
        bit done;
        logic [127:0] l;
        logic [127:0] wline;
        logic [15:0]  expm;
        logic [15:0]  got;
        logic [15:0]  want;
        if (rd && !wr) exp_q.push_back(model_word(addr));
        if (rd && !wr && exp_reads == 0) exp_hits++;
        if (rd && !wr && exp_reads != 0) exp_misses++;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_address = addr;
        mem_wdata = wdata; mem_byte_enable = be;
        cyc = 0; nrd = 0; nwr = 0; wait_cnt = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            pmem_resp = 1'b0;
            pmem_rdata = 128'h0;
            cyc++;
            if (pmem_read || pmem_write) begin
                wait_cnt++;
                n_checks++;
                if (pmem_address !== {addr[15:4], 4'h0}) begin
                    n_fail++;
                    $display("FAIL %s pmem_address: got %h expected %h", name, pmem_address, {addr[15:4], 4'h0});
                end
                if (wait_cnt == LAT) begin
                    pmem_resp = 1'b1;
                    wait_cnt = 0;
                    if (pmem_read) begin
                        nrd++;
                        pmem_rdata = model_line(pmem_address);
                    end else begin
                        nwr++;
                        expm = 16'(be) << (2 * addr[3:1]);
                        wline = {8{wdata}};
                        n_checks++;
                        if (pmem_wmask !== expm) begin
                            n_fail++;
                            $display("FAIL %s pmem_wmask: got %h expected %h", name, pmem_wmask, expm);
                        end
                        n_checks++;
                        if (pmem_wdata !== wline) begin
                            n_fail++;
                            $display("FAIL %s pmem_wdata: got %h expected %h", name, pmem_wdata, wline);
                        end
                        l = model_line({addr[15:4], 4'h0});
                        for (int b = 0; b < 16; b++) begin
                            if (expm[b]) l[8*b +: 8] = wline[8*b +: 8];
                        end
                        pmem_mem[int'({addr[15:4], 4'h0})] = l;
                    end
                end
            end
            @(negedge clk);
            if (mem_resp) begin
                done = 1'b1;
                if (rd && !wr) begin
                    got = mem_rdata;
                    want = exp_q.pop_front();
                    n_checks++;
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL %s mem_rdata: got %h expected %h", name, got, want);
                    end
                end
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: got no mem_resp, required mem_resp within 40 cycles", name);
            exp_q.delete();
        end
        n_checks++;
        if (nrd != exp_reads || nwr != exp_writes) begin
            n_fail++;
            $display("FAIL %s pmem ops: got %0d reads %0d writes expected %0d reads %0d writes",
                     name, nrd, nwr, exp_reads, exp_writes);
        end
        n_checks++;
        if (cyc != exp_cycles) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, exp_cycles);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0124;
        mem_wdata = 16'h0000; mem_byte_enable = 2'b11;
        pmem_resp = 1'b0; pmem_rdata = 128'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || mem_rdata !== 16'h0000 ||
            pmem_address !== 16'h0000 || pmem_wdata !== 128'h0 || pmem_wmask !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset outputs: got resp=%b rd=%b wr=%b addr=%h wmask=%h rdata=%h expected all zero",
                     mem_resp, pmem_read, pmem_write, pmem_address, pmem_wmask, mem_rdata);
        end
        check_stats("reset");
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        access(1'b1, 1'b0, 16'h0124, 16'h0000, 2'b11, 1, 0, LAT + 2, "read_miss");
        check_stats("read_miss");
    endtask

    task automatic test_read_hit();
        access(1'b1, 1'b0, 16'h0126, 16'h0000, 2'b11, 0, 0, 1, "read_hit");
        check_stats("read_hit");
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 16'h0124, 16'h1234, 2'b01, 0, 1, LAT + 1, "write_hit");
        access(1'b1, 1'b0, 16'h0124, 16'h0000, 2'b11, 0, 0, 1, "write_hit_reread");
        n_checks++;
        if (model_word(16'h0124) !== 16'hBE34) begin
            n_fail++;
            $display("FAIL write_hit model: got %h expected be34", model_word(16'h0124));
        end
    endtask

    task automatic test_write_no_alloc();
        access(1'b0, 1'b1, 16'h0500, 16'h5A5A, 2'b11, 0, 1, LAT + 1, "write_miss");
        access(1'b1, 1'b0, 16'h0500, 16'h0000, 2'b11, 1, 0, LAT + 2, "no_alloc_read");
    endtask

    task automatic test_conflict();
        access(1'b1, 1'b0, 16'h0120, 16'h0000, 2'b11, 0, 0, 1, "conflict_first");
        access(1'b1, 1'b0, 16'h01A0, 16'h0000, 2'b11, 1, 0, LAT + 2, "conflict_evict");
        access(1'b1, 1'b0, 16'h0120, 16'h0000, 2'b11, 1, 0, LAT + 2, "conflict_reread");
        check_stats("conflict");
    endtask

    task automatic test_write_wins();
        access(1'b1, 1'b1, 16'h0122, 16'h7777, 2'b11, 0, 1, LAT + 1, "write_wins");
        access(1'b1, 1'b0, 16'h0122, 16'h0000, 2'b11, 0, 0, 1, "write_wins_read");
    endtask

    task automatic test_zero_mask();
        access(1'b0, 1'b1, 16'h0126, 16'hFFFF, 2'b00, 0, 1, LAT + 1, "zero_mask");
        access(1'b1, 1'b0, 16'h0126, 16'h0000, 2'b11, 0, 0, 1, "zero_mask_read");
    endtask

    task automatic test_stray_pmem_resp();
        go_idle();
        pmem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL stray_resp: got resp=%b rd=%b wr=%b rdata=%h expected 0",
                     mem_resp, pmem_read, pmem_write, mem_rdata);
        end
        go_idle();
        access(1'b1, 1'b0, 16'h0126, 16'h0000, 2'b11, 0, 0, 1, "stray_then_hit");
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [5];
        addrs = '{16'h0120, 16'h0122, 16'h0125, 16'h0128, 16'h012E};
        for (int i = 0; i < 5; i++) begin
            access(1'b1, 1'b0, addrs[i], 16'h0000, 2'b11, 0, 0, 1, "back_to_back");
        end
        check_stats("back_to_back");
    endtask

    task automatic test_reset_mid_fill();
        int c;
        go_idle();
        mem_read = 1'b1; mem_address = 16'h0300;
        c = 0;
        while (pmem_read !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (pmem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fill start: got pmem_read=%b expected 1", pmem_read);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pmem_read !== 1'b0 || pmem_address !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_fill reset: got pmem_read=%b addr=%h expected 0", pmem_read, pmem_address);
        end
        exp_hits = 0;
        exp_misses = 0;
        check_stats("mid_fill_reset");
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b1, 1'b0, 16'h0120, 16'h0000, 2'b11, 1, 0, LAT + 2, "after_reset_miss");
        check_stats("after_reset");
    endtask

    initial begin
        logic [127:0] seed;
        seed = 128'h0;
        for (int w = 0; w < 8; w++) seed[16*w +: 16] = 16'h1000 + 16'(w);
        seed[2*16 +: 16] = 16'hBEEF;
        seed[3*16 +: 16] = 16'hCAFE;
        pmem_mem[int'(16'h0120)] = seed;

        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_no_alloc();
        test_conflict();
        test_write_wins();
        test_zero_mask();
        test_stray_pmem_resp();
        test_back_to_back();
        test_reset_mid_fill();
        go_idle();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
